// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor: branch opcode,
// 2-bit counter encodings and the saturating counter step.
package branch_predictor_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    function automatic ctr_e ctr_next(input ctr_e state, input logic taken);
        ctr_e stepped;
        stepped = state;
        if (taken) begin
            case (state)
                SNT:     stepped = WNT;
                WNT:     stepped = WT;
                default: stepped = ST;
            endcase
        end else begin
            case (state)
                ST:      stepped = WT;
                WT:      stepped = WNT;
                default: stepped = SNT;
            endcase
        end
        return stepped;
    endfunction

    function automatic logic ctr_is_taken(input ctr_e state);
        return (state == WT) || (state == ST);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Combinational 2-bit saturating counter step used on the training path.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  ctr_e state,
    input  logic taken,
    output ctr_e stepped
);

    always_comb begin
        stepped = ctr_next(state, taken);
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal BHT + direct-mapped BTB branch predictor with registered redirect.
// Define BP_GSHARE_EN to XOR a global history register into the BHT index.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned TAG_W = 24,
    parameter int unsigned GHR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_valid,
    input  logic [31:0]      f_pc,
    output logic             p_taken,
    output logic [31:0]      p_target,
`ifdef BP_GSHARE_EN
    output logic [GHR_W-1:0] p_ghr,
    input  logic [GHR_W-1:0] u_ghr,
`endif
    input  logic             u_valid,
    input  logic [6:0]       u_op,
    input  logic [31:0]      u_pc,
    input  logic             u_taken,
    input  logic [31:0]      u_target,
    input  logic             u_pred_taken,
    input  logic [31:0]      u_pred_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic             btb_valid  [DEPTH];
    logic [TAG_W-1:0] btb_tag    [DEPTH];
    logic [31:0]      btb_target [DEPTH];
    ctr_e             ctr        [DEPTH];

    logic [IDX_W-1:0] f_btb_idx;
    logic [IDX_W-1:0] f_ctr_idx;
    logic [IDX_W-1:0] u_btb_idx;
    logic [IDX_W-1:0] u_ctr_idx;
    logic [TAG_W-1:0] f_tag;
    logic [TAG_W-1:0] u_tag;
    logic             f_hit;
    logic             u_hit;
    logic             u_branch;
    logic             u_misp;
    ctr_e             ctr_step;
    logic             unused;

    assign f_btb_idx = f_pc[IDX_W+1:2];
    assign u_btb_idx = u_pc[IDX_W+1:2];
    assign f_tag     = f_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign u_tag     = u_pc[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr;

    assign f_ctr_idx = f_btb_idx ^ IDX_W'(ghr);
    assign u_ctr_idx = u_btb_idx ^ IDX_W'(u_ghr);
    assign p_ghr     = ghr;
    assign unused    = &{1'b0, f_pc[1:0], u_pc[1:0], u_ghr[GHR_W-1]};

    // A mispredict rebuilds history from the copy that travelled with the branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (u_branch) begin
            if (u_misp) begin
                ghr <= {u_ghr[GHR_W-2:0], u_taken};
            end else begin
                ghr <= {ghr[GHR_W-2:0], u_taken};
            end
        end
    end
`else
    assign f_ctr_idx = f_btb_idx;
    assign u_ctr_idx = u_btb_idx;
    assign unused    = &{1'b0, f_pc[1:0], u_pc[1:0]};
`endif

    always_comb begin
        f_hit    = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == f_tag);
        p_taken  = f_valid && f_hit && ctr_is_taken(ctr[f_ctr_idx]);
        p_target = p_taken ? btb_target[f_btb_idx] : f_pc + 32'd4;
    end

    always_comb begin
        u_branch = u_valid && (u_op == OP_BRANCH);
        u_hit    = btb_valid[u_btb_idx] && (btb_tag[u_btb_idx] == u_tag);
        u_misp   = (u_taken != u_pred_taken) ||
                   (u_taken && (u_target != u_pred_target));
    end

    bp_sat_counter u_sat_counter (
        .state   (ctr[u_ctr_idx]),
        .taken   (u_taken),
        .stepped (ctr_step)
    );

    // A miss only allocates when taken; a fresh entry starts weakly taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                ctr[i]        <= WNT;
            end
        end else if (u_branch) begin
            if (u_hit) begin
                ctr[u_ctr_idx] <= ctr_step;
                if (u_taken) begin
                    btb_target[u_btb_idx] <= u_target;
                end
            end else if (u_taken) begin
                btb_valid[u_btb_idx]  <= 1'b1;
                btb_tag[u_btb_idx]    <= u_tag;
                btb_target[u_btb_idx] <= u_target;
                ctr[u_ctr_idx]        <= WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            mispredict <= u_branch && u_misp;
            if (u_branch && u_misp) begin
                redirect_pc <= u_taken ? u_target : u_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (default bimodal build, default parameters).
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        p_taken;
    logic [31:0] p_target;
    logic        u_valid;
    logic [6:0]  u_op;
    logic [31:0] u_pc;
    logic        u_taken;
    logic [31:0] u_target;
    logic        u_pred_taken;
    logic [31:0] u_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per-entry valid/tag/target and an integer counter 0..3.
    bit          m_valid  [64];
    bit [23:0]   m_tag    [64];
    bit [31:0]   m_target [64];
    int          m_cnt    [64];
    bit          m_misp;
    bit [31:0]   m_redir;

    branch_predictor #(.IDX_W(6), .TAG_W(24), .GHR_W(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .f_valid       (f_valid),
        .f_pc          (f_pc),
        .p_taken       (p_taken),
        .p_target      (p_target),
        .u_valid       (u_valid),
        .u_op          (u_op),
        .u_pc          (u_pc),
        .u_taken       (u_taken),
        .u_target      (u_target),
        .u_pred_taken  (u_pred_taken),
        .u_pred_target (u_pred_target),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_cnt[i]    = 1;
        end
        m_misp  = 1'b0;
        m_redir = '0;
    endfunction

    function automatic void model_predict(input bit v, input bit [31:0] pc,
                                          output bit tk, output bit [31:0] tgt);
        int i;
        i   = int'(pc[7:2]);
        tk  = v && m_valid[i] && (m_tag[i] == pc[31:8]) && (m_cnt[i] >= 2);
        tgt = tk ? m_target[i] : pc + 32'd4;
    endfunction

    function automatic void model_edge();
        int i;
        bit hit;
        bit wrong;
        i = int'(u_pc[7:2]);
        if (u_valid && u_op == 7'b1100011) begin
            wrong = (u_taken != u_pred_taken) || (u_taken && u_target != u_pred_target);
            m_misp = wrong;
            if (wrong) m_redir = u_taken ? u_target : u_pc + 32'd4;
            hit = m_valid[i] && (m_tag[i] == u_pc[31:8]);
            if (hit) begin
                m_cnt[i] = u_taken ? ((m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1)
                                   : ((m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1);
                if (u_taken) m_target[i] = u_target;
            end else if (u_taken) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = u_pc[31:8];
                m_target[i] = u_target;
                m_cnt[i]    = 2;
            end
        end else begin
            m_misp = 1'b0;
        end
    endfunction

    task automatic drive(input bit [6:0] op, input bit [31:0] pc, input bit tk,
                         input bit [31:0] tgt, input bit ptk, input bit [31:0] ptgt);
        u_valid = 1'b1; u_op = op; u_pc = pc; u_taken = tk;
        u_target = tgt; u_pred_taken = ptk; u_pred_target = ptgt;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
        u_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (mispredict !== 1'b0) $display("FAIL reset_misp got %b want 0", mispredict); else n_pass++;
        n_checks++;
        if (redirect_pc !== 32'h0) $display("FAIL reset_redirect got %h want 0", redirect_pc); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        f_valid = 1'b1; f_pc = 32'h100;
        #1;
        n_checks++;
        if (p_taken !== 1'b0) $display("FAIL reset_ptaken got %b want 0", p_taken); else n_pass++;
        n_checks++;
        if (p_target !== 32'h104) $display("FAIL reset_ptarget got %h want 104", p_target); else n_pass++;
    endtask

    task automatic test_train();
        bit mtk;
        bit [31:0] mtgt;
        drive(7'b1100011, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        edge_step();
        n_checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h80)
            $display("FAIL train_alloc_misp got %b/%h want 1/00000080", mispredict, redirect_pc);
        else n_pass++;
        f_valid = 1'b1; f_pc = 32'h100; #1;
        n_checks++;
        if (p_taken !== 1'b1 || p_target !== 32'h80)
            $display("FAIL train_alloc_pred got %b/%h want 1/00000080", p_taken, p_target);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            model_predict(1'b1, 32'h100, mtk, mtgt);
            drive(7'b1100011, 32'h100, 1'b0, 32'h80, mtk, mtgt);
            edge_step();
            n_checks++;
            if (mispredict !== m_misp || redirect_pc !== m_redir)
                $display("FAIL train_nt_misp[%0d] got %b/%h want %b/%h", k, mispredict, redirect_pc, m_misp, m_redir);
            else n_pass++;
            n_checks++;
            if (p_taken !== 1'b0 || p_target !== 32'h104)
                $display("FAIL train_nt_pred[%0d] got %b/%h want 0/00000104", k, p_taken, p_target);
            else n_pass++;
        end
        // From saturated 00, two takens are needed to predict taken again.
        for (int k = 0; k < 2; k++) begin
            model_predict(1'b1, 32'h100, mtk, mtgt);
            drive(7'b1100011, 32'h100, 1'b1, 32'h80, mtk, mtgt);
            edge_step();
            n_checks++;
            if (p_taken !== 1'(k))
                $display("FAIL train_sat_pred[%0d] got %b want %b", k, p_taken, 1'(k));
            else n_pass++;
        end
    endtask

    task automatic test_alias();
        f_valid = 1'b1; f_pc = 32'h200; #1;
        n_checks++;
        if (p_taken !== 1'b0 || p_target !== 32'h204)
            $display("FAIL alias_pred got %b/%h want 0/00000204", p_taken, p_target);
        else n_pass++;
        drive(7'b0110011, 32'h200, 1'b1, 32'h40, 1'b0, 32'h204);
        edge_step();
        n_checks++;
        if (mispredict !== 1'b0) $display("FAIL nonbranch_misp got %b want 0", mispredict); else n_pass++;
        n_checks++;
        if (p_taken !== 1'b0) $display("FAIL nonbranch_alloc got %b want 0", p_taken); else n_pass++;
        f_pc = 32'h100; #1;
        n_checks++;
        if (p_taken !== 1'b1 || p_target !== 32'h80)
            $display("FAIL nonbranch_keep got %b/%h want 1/00000080", p_taken, p_target);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(7'b1100011, 32'h100, 1'b1, 32'h80, 1'b1, 32'h90);
        edge_step();
        u_valid = 1'b1;
        n_checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h80)
            $display("FAIL target_mismatch got %b/%h want 1/00000080", mispredict, redirect_pc);
        else n_pass++;
        drive(7'b1100011, 32'h104, 1'b1, 32'h44, 1'b0, 32'h108);
        edge_step();
        n_checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h44)
            $display("FAIL b2b_second got %b/%h want 1/00000044", mispredict, redirect_pc);
        else n_pass++;
        edge_step();
        n_checks++;
        if (mispredict !== 1'b0 || redirect_pc !== 32'h44)
            $display("FAIL b2b_idle got %b/%h want 0/00000044", mispredict, redirect_pc);
        else n_pass++;
    endtask

    function automatic bit [31:0] rand_pc();
        bit [23:0] tag;
        bit [5:0]  idx;
        tag = 24'($urandom_range(1, 2));
        idx = 6'($urandom_range(0, 3));
        return {tag, idx, 2'b00};
    endfunction

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bit [31:0] upc, tgt, ptgt, mtgt, etgt;
            bit tk, ptk, mtk, etk;
            f_valid = ($urandom_range(0, 3) != 0);
            f_pc    = rand_pc();
            upc = rand_pc();
            tk  = 1'($urandom_range(0, 1));
            tgt = 32'h1000 + 32'($urandom_range(0, 3) * 4);
            model_predict(1'b1, upc, mtk, mtgt);
            if ($urandom_range(0, 3) != 0) begin
                ptk = mtk; ptgt = mtgt;
            end else begin
                ptk = 1'($urandom_range(0, 1));
                ptgt = 32'h1000 + 32'($urandom_range(0, 3) * 4);
            end
            drive(($urandom_range(0, 7) == 0) ? 7'b0110011 : 7'b1100011, upc, tk, tgt, ptk, ptgt);
            u_valid = ($urandom_range(0, 5) != 0);
            #1;
            model_predict(f_valid, f_pc, etk, etgt);
            n_checks++;
            if (p_taken !== etk || p_target !== etgt)
                $display("FAIL rand_pred[%0d] pc=%h got %b/%h want %b/%h", k, f_pc, p_taken, p_target, etk, etgt);
            else n_pass++;
            edge_step();
            n_checks++;
            if (mispredict !== m_misp || redirect_pc !== m_redir)
                $display("FAIL rand_misp[%0d] got %b/%h want %b/%h", k, mispredict, redirect_pc, m_misp, m_redir);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        drive(7'b1100011, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        edge_step();
        n_checks++;
        if (mispredict !== 1'b1) $display("FAIL midrst_pre got %b want 1", mispredict); else n_pass++;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (mispredict !== 1'b0 || redirect_pc !== 32'h0)
            $display("FAIL midrst_async got %b/%h want 0/00000000", mispredict, redirect_pc);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        f_valid = 1'b1; f_pc = 32'h100; #1;
        n_checks++;
        if (p_taken !== 1'b0 || p_target !== 32'h104)
            $display("FAIL midrst_entry got %b/%h want 0/00000104", p_taken, p_target);
        else n_pass++;
        // Update presented, then reset lands before its edge: it must be dropped.
        drive(7'b1100011, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        u_valid = 1'b0;
        f_pc = 32'h300; #1;
        n_checks++;
        if (p_taken !== 1'b0 || mispredict !== 1'b0)
            $display("FAIL midrst_pending got %b/%b want 0/0", p_taken, mispredict);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; f_valid = 1'b0; f_pc = '0;
        u_valid = 1'b0; u_op = '0; u_pc = '0; u_taken = 1'b0;
        u_target = '0; u_pred_taken = 1'b0; u_pred_target = '0;
        model_reset();
        test_reset();
        test_train();
        test_alias();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart to the execute-stage branch comparator.
- Predicts taken/not-taken and the target for conditional branches at fetch, using a BHT of 2-bit saturating counters plus a direct-mapped BTB.
- Trains on resolved outcomes returned from execute.
- Raises a registered mispredict/redirect to the fetch PC mux.

Parameters:
- IDX_W, 6, index bits; table depth = 2**IDX_W, indexed by pc[IDX_W+1:2].
- TAG_W, 24, BTB tag bits = pc[IDX_W+TAG_W+1:IDX_W+2]; IDX_W+TAG_W must be ≤ 30.
- GHR_W, 6, global history length; used only with BP_GSHARE_EN, and GHR_W must be ≤ IDX_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_valid  in  1  fetch PC valid.
- f_pc  in  32  fetch PC.
- p_taken  out  1  predicted taken (combinational).
- p_target  out  32  predicted next PC (combinational).
- u_valid  in  1  resolved instruction valid at execute.
- u_op  in  7  opcode of resolved instruction.
- u_pc  in  32  PC of resolved instruction.
- u_taken  in  1  actual outcome from branch comparator.
- u_target  in  32  actual branch target (pc+imm).
- u_pred_taken  in  1  prediction carried down the pipe.
- u_pred_target  in  32  predicted next PC carried down the pipe.
- mispredict  out  1  registered redirect request.
- redirect_pc  out  32  registered correct next PC.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - All BTB valid bits cleared; all counters set to 2'b01 (weakly not-taken).
  - mispredict=0, redirect_pc=0.
  - Asserting reset between u_valid and the following edge discards the pending update.
- Prediction, 0-cycle, asynchronous table read:
  - hit = btb_valid[i] && btb_tag[i]==f_pc tag field.
  - p_taken = f_valid && hit && ctr[i][1].
  - p_target = p_taken ? btb_target[i] : f_pc+4 (32-bit wrap).
  - With f_valid=0: p_taken=0 and p_target=f_pc+4.
- Update: occurs only on a clock edge with u_valid && u_op==7'b1100011. Other opcodes cause no table change and no mispredict.
  - Counter: taken → saturating increment to max 2'b11; not-taken → saturating decrement to min 2'b00.
  - BTB hit && taken: counter incremented, target overwritten with u_target.
  - BTB miss && taken: allocate (valid=1, tag, target); counter set to 2'b10, not incremented.
  - BTB miss && not-taken: no allocation; the counter at that index is left unchanged.
- Same-cycle fetch read and update of the same index: fetch sees the pre-update value (no bypass).
- Mispredict, registered with 1-cycle latency:
  - Condition, for a valid branch: u_taken!=u_pred_taken, OR (u_taken && u_target!=u_pred_target).
  - Next cycle: mispredict=1 and redirect_pc = u_taken ? u_target : u_pc+4.
  - Otherwise mispredict=0 and redirect_pc holds its last value.
  - Pulses on back-to-back mispredicts are independent, one per cycle.

Optional Feature:
- BP_GSHARE_EN defined:
  - Adds a GHR_W-bit global history register, reset 0.
  - Adds ports p_ghr out GHR_W (current GHR, sampled with the prediction) and u_ghr in GHR_W (carried down the pipe).
  - BHT index becomes pc idx XOR zero-extended GHR: fetch uses the GHR, update uses u_ghr.
  - BTB stays pc-indexed.
  - GHR shifts left with u_taken on each valid branch.
  - On mispredict, the GHR is repaired to {u_ghr[GHR_W-2:0],u_taken}.
- BP_GSHARE_EN undefined: pure bimodal, no GHR, no extra ports.

Decomposition:
- Shared package: OP_BRANCH=7'b1100011 (shared with the comparator), counter encodings SNT/WNT/WT/ST, and the 2-bit counter next-state function.
- One natural sub-module, bp_sat_counter: a combinational 2-bit saturating step, instantiated on the update path.

Test Plan:
- Reset, then f_pc=0x100 → p_taken=0, p_target=0x104; mispredict=0.
- Update BEQ u_pc=0x100, taken, target 0x80, pred 0 → next cycle mispredict=1, redirect_pc=0x80; then f_pc=0x100 → p_taken=1, p_target=0x80.
- Same entry: not-taken ×3 → counter 10→01→00→00 (saturates); p_taken=0 after the first; redirect_pc=0x104 on each mispredicted edge.
- Alias: u_pc=0x100 vs f_pc=0x200 (same idx, different tag) → miss, p_taken=0; non-branch u_op=0110011 with u_valid=1 → no table change, no mispredict.
- Taken with u_pred_taken=1 but u_pred_target=0x90 ≠ 0x80 → mispredict=1, redirect_pc=0x80.
- Assert rst_n=0 mid-stream with a trained entry and mispredict=1 → outputs 0 immediately; entry invalid after release.
